// File: rtl/spi_mem_arb_pkg.sv
// spi_mem_arb_pkg: shared FSM states, SPI memory opcodes and frame length.
package spi_mem_arb_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam int FRAME_BITS = 40;
endpackage

// File: rtl/spi_frame_shifter.sv
// spi_frame_shifter: mode-0 SCK divider, 40-bit MOSI shift register and MISO capture.
module spi_frame_shifter
  import spi_mem_arb_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  en,
  input  logic [FRAME_BITS-1:0] frame_i,
  input  logic                  miso_i,
  output logic                  sclk_o,
  output logic                  mosi_o,
  output logic                  last_o,
  output logic [7:0]            rx_o
);
  localparam logic [3:0] DM = 4'(CLK_DIV - 1);
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [5:0] idx_q, idx_d;
  logic [3:0] div_q, div_d;
  logic sclk_q, sclk_d;
  logic [7:0] rx_q, rx_d;
  logic tick;
  // Each tick ends a half-period; the low->high tick samples MISO, the high->low tick advances MOSI.
  always_comb begin
    tick = en && div_q == DM;
    sr_d = sr_q;
    idx_d = idx_q;
    div_d = div_q;
    sclk_d = sclk_q;
    rx_d = rx_q;
    if (load) begin
      sr_d = frame_i;
      idx_d = 6'd0;
      div_d = 4'd0;
      sclk_d = 1'b0;
    end else if (en) begin
      div_d = tick ? 4'd0 : div_q + 4'd1;
      sclk_d = tick ? !sclk_q : sclk_q;
      rx_d = (tick && !sclk_q) ? {rx_q[6:0], miso_i} : rx_q;
      sr_d = (tick && sclk_q) ? {sr_q[FRAME_BITS-2:0], 1'b0} : sr_q;
      idx_d = (tick && sclk_q) ? idx_q + 6'd1 : idx_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
      idx_q <= 6'd0;
      div_q <= 4'd0;
      sclk_q <= 1'b0;
      rx_q <= 8'h00;
    end else begin
      sr_q <= sr_d;
      idx_q <= idx_d;
      div_q <= div_d;
      sclk_q <= sclk_d;
      rx_q <= rx_d;
    end
  end
  assign sclk_o = sclk_q;
  assign mosi_o = sr_q[FRAME_BITS-1];
  assign last_o = tick && sclk_q && idx_q == 6'(FRAME_BITS - 1);
  assign rx_o = rx_q;
endmodule

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: round-robin arbiter sharing one SPI memory between two requesters.
module spi_mem_arbiter
  import spi_mem_arb_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_i,
  input  logic [1:0]  we_i,
  input  logic [23:0] addr0_i,
  input  logic [23:0] addr1_i,
  input  logic [7:0]  wdata0_i,
  input  logic [7:0]  wdata1_i,
  output logic [7:0]  rdata_o,
  output logic [1:0]  done_o,
  output logic        busy_o,
  output logic        spi_sclk_o,
  output logic        spi_mosi_o,
  output logic        spi_cs_n_o,
  input  logic        spi_miso_i
);
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("CLK_DIV must be within 1..16");
  end
  localparam logic [3:0] DM = 4'(CLK_DIV - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic gnt_q, gnt_d, last_q, last_d, we_q, we_d;
  logic [7:0] rdata_q, rdata_d;
  logic pick, cnt_end, load, shift_last;
  logic [7:0] rx;
  logic [FRAME_BITS-1:0] frame;
  always_comb begin
    pick = &req_i ? !last_q : req_i[1];
    frame = pick ? {we_i[1] ? CMD_WRITE : CMD_READ, addr1_i, we_i[1] ? wdata1_i : 8'h00}
                 : {we_i[0] ? CMD_WRITE : CMD_READ, addr0_i, we_i[0] ? wdata0_i : 8'h00};
    load = state_q == S_IDLE && |req_i;
    cnt_end = cnt_q == DM;
    cnt_d = (state_q == S_IDLE || state_q == S_SHIFT || cnt_end) ? 4'd0 : cnt_q + 4'd1;
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    we_d = we_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        state_d = load ? S_SETUP : S_IDLE;
        gnt_d = load ? pick : gnt_q;
        last_d = load ? pick : last_q;
        we_d = load ? we_i[pick] : we_q;
      end
      S_SETUP: state_d = cnt_end ? S_SHIFT : S_SETUP;
      S_SHIFT: state_d = shift_last ? S_HOLD : S_SHIFT;
      S_HOLD: begin
        state_d = cnt_end ? S_GAP : S_HOLD;
        rdata_d = (cnt_end && !we_q) ? rx : rdata_q;
      end
      S_GAP: state_d = cnt_end ? S_IDLE : S_GAP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= 4'd0;
      gnt_q <= 1'b0;
      last_q <= 1'b1;
      we_q <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      we_q <= we_d;
      rdata_q <= rdata_d;
    end
  end
  spi_frame_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk(clk),
    .rst(rst),
    .load(load),
    .en(state_q == S_SHIFT),
    .frame_i(frame),
    .miso_i(spi_miso_i),
    .sclk_o(spi_sclk_o),
    .mosi_o(spi_mosi_o),
    .last_o(shift_last),
    .rx_o(rx)
  );
  assign spi_cs_n_o = state_q == S_IDLE || state_q == S_GAP;
  assign busy_o = state_q != S_IDLE;
  // Done fires only in the first GAP cycle, so at most one bit is ever set.
  assign done_o = (state_q == S_GAP && cnt_q == 4'd0) ? {gnt_q, !gnt_q} : 2'b00;
  assign rdata_o = rdata_q;
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: cycle-accurate frame-schedule model plus directed SPI memory transactions.
module tb_spi_mem_arbiter;
  localparam int D = 2;
  logic clk = 0, rst = 1;
  logic [1:0] req = 0, we = 0;
  logic [23:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic [7:0] rdata;
  logic [1:0] done;
  logic busy, sclk, mosi, cs_n, miso;
  logic b_req = 0;
  logic [23:0] b_addr = 0;
  logic [7:0] b_rdata;
  logic [1:0] b_done;
  logic b_busy, b_sclk, b_mosi, b_cs_n, b_miso;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] resp = 0, b_resp = 0;
  int scnt = 0, b_scnt = 0;
  logic [39:0] cap = 0, b_cap = 0;

  always #5 clk = ~clk;

  spi_mem_arbiter #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr0_i(addr0), .addr1_i(addr1),
    .wdata0_i(wdata0), .wdata1_i(wdata1), .rdata_o(rdata), .done_o(done), .busy_o(busy),
    .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_cs_n_o(cs_n), .spi_miso_i(miso)
  );
  spi_mem_arbiter #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .req_i({1'b0, b_req}), .we_i(2'b00), .addr0_i(b_addr), .addr1_i(24'h0),
    .wdata0_i(8'h00), .wdata1_i(8'h00), .rdata_o(b_rdata), .done_o(b_done), .busy_o(b_busy),
    .spi_sclk_o(b_sclk), .spi_mosi_o(b_mosi), .spi_cs_n_o(b_cs_n), .spi_miso_i(b_miso)
  );

  // Memory slaves: capture MOSI on SCK rise, present the read byte for rising edges 33..40.
  always @(negedge cs_n) begin scnt = 0; cap = 0; end
  always @(posedge sclk) begin cap = {cap[38:0], mosi}; scnt++; end
  assign miso = (scnt >= 32 && scnt < 40) ? resp[3'(39 - scnt)] : 1'b0;
  always @(negedge b_cs_n) begin b_scnt = 0; b_cap = 0; end
  always @(posedge b_sclk) begin b_cap = {b_cap[38:0], b_mosi}; b_scnt++; end
  assign b_miso = (b_scnt >= 32 && b_scnt < 40) ? b_resp[3'(39 - b_scnt)] : 1'b0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // Model: a frame started in cycle s owns cycles s+1 .. s+83*D.
  logic m_act = 0, m_g = 0, m_last = 1, m_we = 0, armed = 0;
  int m_s = 0;
  logic [39:0] m_frame = 0;
  logic [7:0] m_resp = 0, m_rdata = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_act = 0;
      m_last = 1;
      m_rdata = 0;
      armed = 1;
    end else if ((!m_act || cyc - m_s > 83 * D) && req != 2'b00) begin
      m_act = 1;
      m_s = cyc;
      m_g = (req == 2'b11) ? !m_last : req[1];
      m_last = m_g;
      m_we = we[m_g];
      m_frame = m_g ? {m_we ? 8'h02 : 8'h03, addr1, m_we ? wdata1 : 8'h00}
                    : {m_we ? 8'h02 : 8'h03, addr0, m_we ? wdata0 : 8'h00};
      m_resp = resp;
    end
    cyc++;
  end

  logic prev_mosi = 0;
  always @(negedge clk) begin
    int off;
    logic ec, eb, es;
    logic [1:0] ed;
    if (armed) begin
      off = cyc - m_s;
      ec = !(m_act && off >= 1 && off <= 82 * D);
      eb = m_act && off >= 1 && off <= 83 * D;
      es = m_act && off > D && off <= 81 * D && ((off - D - 1) / D) % 2 == 1;
      ed = (m_act && off == 82 * D + 1) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
      if (ed != 2'b00 && !m_we) m_rdata = m_resp;
      chk("cycle cs_n/busy/sclk/done/rdata", 64'({cs_n, busy, sclk, done, rdata}), 64'({ec, eb, es, ed, m_rdata}));
      if (ed != 2'b00) begin
        chk("frame_bits", 64'(cap), 64'(m_frame));
        chk("sck_rises", 64'(scnt), 64'd40);
      end
      if (mosi !== prev_mosi && sclk) chk("mosi_changed_sck_high", 1, 0);
      prev_mosi = mosi;
    end
  end

  task automatic wait_done(input int lim, output logic [1:0] d, output int at);
    d = 0;
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done != 2'b00) begin d = done; at = cyc; return; end
    end
    chk("done_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_bits(input int nb);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!cs_n && scnt >= nb) return;
    end
    chk("bits_timeout", 1, 0);
  endtask

  initial begin
    logic [1:0] d;
    int n, at, prev, hi;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 64'({cs_n, sclk, mosi, done, busy, rdata}), 64'({1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00}));
    @(posedge clk); #1 rst = 0;
    // Read by requester 0
    @(posedge clk); #1 resp = 8'hA5; addr0 = 24'h012345; we = 2'b00; req = 2'b01; n = cyc;
    @(posedge clk); #1 req = 2'b00;
    wait_done(400, d, at);
    chk("t1_done", 64'(d), 64'h1);
    chk("t1_latency", 64'(at - n), 64'd165);
    chk("t1_rdata", 64'(rdata), 64'hA5);
    chk("t1_mosi", 64'(cap), 64'h0301234500);
    // Write by requester 1
    wait_idle();
    @(posedge clk); #1 addr1 = 24'hFFFFFF; wdata1 = 8'h3C; we = 2'b10; req = 2'b10; n = cyc;
    @(posedge clk); #1 req = 2'b00;
    wait_done(400, d, at);
    chk("t2_done", 64'(d), 64'h2);
    chk("t2_latency", 64'(at - n), 64'd165);
    chk("t2_rdata_kept", 64'(rdata), 64'hA5);
    chk("t2_mosi", 64'(cap), 64'h02FFFFFF3C);
    chk("t2_rises", 64'(scnt), 64'd40);
    // Both requests held from reset: alternate 0,1,0,1 back-to-back
    wait_idle();
    @(posedge clk); #1 rst = 1; we = 2'b00;
    @(posedge clk); #1 rst = 0; resp = 8'h11; addr0 = 24'h000100; addr1 = 24'h000200; req = 2'b11;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_done(400, d, at);
      chk($sformatf("t3_grant%0d", k), 64'(d), (k % 2) ? 64'h2 : 64'h1);
      if (k > 0) chk($sformatf("t3_spacing%0d", k), 64'(at - prev), 64'd167);
      prev = at;
      if (k == 3) req = 2'b00;
    end
    chk("t3_rdata", 64'(rdata), 64'h11);
    // Reset mid-frame aborts with no done
    wait_idle();
    @(posedge clk); #1 resp = 8'h77; addr0 = 24'h000040; req = 2'b01;
    @(posedge clk); #1 req = 2'b00;
    wait_bits(20);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t4_abort", 64'({cs_n, sclk, busy, done}), 64'({1'b1, 1'b0, 1'b0, 2'b00}));
    hi = 0;
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (done != 2'b00) hi++; end
    chk("t4_no_done", 64'(hi), 64'd0);
    @(posedge clk); #1 resp = 8'h5A; addr0 = 24'h000010; req = 2'b01; n = cyc;
    @(posedge clk); #1 req = 2'b00;
    wait_done(400, d, at);
    chk("t4_done", 64'(d), 64'h1);
    chk("t4_latency", 64'(at - n), 64'd165);
    chk("t4_rdata", 64'(rdata), 64'h5A);
    chk("t4_mosi", 64'(cap), 64'h0300001000);
    // Request dropped and inputs changed mid-frame
    wait_idle();
    @(posedge clk); #1 resp = 8'h3C; addr0 = 24'h00BEEF; req = 2'b01; n = cyc;
    wait_bits(5);
    @(posedge clk); #1 req = 2'b00; addr0 = 24'h123456; we = 2'b01; wdata0 = 8'hFF;
    wait_done(400, d, at);
    chk("t5_done", 64'(d), 64'h1);
    chk("t5_latency", 64'(at - n), 64'd165);
    chk("t5_mosi", 64'(cap), 64'h0300BEEF00);
    chk("t5_rdata", 64'(rdata), 64'h3C);
    we = 2'b00;
    // CLK_DIV=1 read
    wait_idle();
    @(posedge clk); #1 b_resp = 8'h96; b_addr = 24'hABCDEF; b_req = 1; n = cyc;
    @(posedge clk); #1 b_req = 0;
    hi = 0;
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b_sclk) hi++;
      if (b_done != 2'b00) begin at = cyc; break; end
    end
    chk("d1_done", 64'(b_done), 64'h1);
    chk("d1_latency", 64'(at - n), 64'd83);
    chk("d1_rdata", 64'(b_rdata), 64'h96);
    chk("d1_mosi", 64'(b_cap), 64'h03ABCDEF00);
    chk("d1_sck_high_cycles", 64'(hi), 64'd40);
    chk("d1_rises", 64'(b_scnt), 64'd40);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_mem_arbiter.md
SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 2: SCK half-period in clk cycles; legal range 1..16; elaboration SHALL fail outside this range.
REQ-002 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_i  input  2  per-requester transaction request; bit0 = requester 0, bit1 = requester 1.
REQ-005 we_i  input  2  per-requester write (1) / read (0) select.
REQ-006 addr0_i, addr1_i  input  24 each  SPI memory byte address per requester.
REQ-007 wdata0_i, wdata1_i  input  8 each  write data per requester.
REQ-008 rdata_o  output  8  last read byte.
REQ-009 done_o  output  2  one-cycle completion pulse per requester.
REQ-010 busy_o  output  1  high in any state other than IDLE.
REQ-011 spi_sclk_o, spi_mosi_o, spi_cs_n_o  output  1 each  SPI master pins; spi_miso_i  input  1.

Function
REQ-012 Frame SHALL be 40 bits, MSB first: cmd (0x03 read, 0x02 write), addr[23:16], addr[15:8], addr[7:0], data byte (wdata for write, 0x00 for read).
REQ-013 SPI mode 0: MOSI changes only while SCK low; MISO sampled on SCK rising edge; SCK idles low.
REQ-014 States: IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-015 IDLE: when any req_i bit is sampled high, grant one requester, latch its we/addr/wdata, go to SETUP; CS low from the next cycle.
REQ-016 Round-robin: if both requests are high, grant the requester not granted last; a single request is granted immediately.
REQ-017 SETUP: CLK_DIV cycles, CS low, SCK low, MOSI = bit 39.
REQ-018 SHIFT: 80*CLK_DIV cycles; per bit: CLK_DIV cycles SCK low, then CLK_DIV cycles SCK high.
REQ-019 HOLD: CLK_DIV cycles, CS low, SCK low; then GAP.
REQ-020 GAP: CS high, SCK low, CLK_DIV cycles, then IDLE; done_o[grant] SHALL pulse in the first GAP cycle.
REQ-021 Latency: req sampled at cycle N gives CS low during N+1 .. N+(80+2)*CLK_DIV and done at N+(80+2)*CLK_DIV+1; with CLK_DIV=2 that is CS low N+1..N+164 and done at N+165.
REQ-022 Read: MISO bits sampled on rising edges 33..40 SHALL form rdata_o, updated in the done cycle and held until the next read done; writes leave rdata_o unchanged.
REQ-023 Inputs are latched at grant; dropping req_i or changing inputs mid-frame SHALL NOT alter the frame, and done still pulses.
REQ-024 A request held high after done SHALL be re-granted after GAP, back-to-back, if the other requester is idle.
REQ-025 At most one done_o bit SHALL be high in any cycle.

Reset
REQ-026 rst high at any clock edge SHALL set: state IDLE, spi_cs_n_o=1, spi_sclk_o=0, spi_mosi_o=0, done_o=0, busy_o=0, rdata_o=0x00, last-grant=1 (requester 0 wins first); no done for an aborted frame.

Structure
REQ-027 Package spi_mem_arb_pkg SHALL hold the state enum, CMD_READ=8'h03, CMD_WRITE=8'h02, FRAME_BITS=40.
REQ-028 One sub-module spi_frame_shifter SHALL own the 40-bit shift register, bit counter, SCK divider and MISO capture; the arbiter FSM sequences it.

Verification
REQ-029 CLK_DIV=2, read req0 addr 0x012345, MISO model returns 0xA5 -> MOSI 03 01 23 45 00, rdata_o=0xA5, done_o=01 at N+165.
REQ-030 Write req1 addr 0xFFFFFF wdata 0x3C -> MOSI 02 FF FF FF 3C, exactly 40 SCK rising edges, rdata_o unchanged, done_o=10.
REQ-031 Both requests high from reset, held -> grants 0,1,0,1; CS high at least CLK_DIV cycles between frames; never two done bits together.
REQ-032 rst pulsed during bit 20 -> next cycle cs_n=1, sclk=0, busy=0, no done; a following req0 completes normally.
REQ-033 req0 dropped after bit 5 -> frame completes, done_o=01; CLK_DIV=1 read -> SCK=clk/2, done at N+83.
